// File: rtl/gen_synchronizer.sv
// Generation synchronizer: paces logic-engine generations against rendered frames
// and hands the write buffer to the display once every engine and the renderer are done.
module gen_synchronizer #(
   parameter int NUM_ENGINES = 4,
   parameter int DIV_WIDTH   = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [NUM_ENGINES-1:0] logic_done_in,
   input  logic                   render_done_in,
   input  logic                   buf_ready_in,
   input  logic [1:0]             mode_in,
   input  logic                   step_in,
   input  logic [DIV_WIDTH-1:0]   frame_div_in,
   output logic                   logic_start_out,
   output logic                   buf_swap_out,
   output logic                   busy_out,
   output logic [15:0]            gen_count_out
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BUF,
      COMPUTE,
      WAIT_RENDER,
      SWAP
   } state_t;

   state_t                 state_q;
   logic [NUM_ENGINES-1:0] doneMask_q;
   logic [NUM_ENGINES-1:0] doneMerged;
   logic [DIV_WIDTH-1:0]   frameCnt_q;
   logic [DIV_WIDTH-1:0]   frameCnt_d;
   logic [DIV_WIDTH-1:0]   divEff;
   logic                   stepPending_q;
   logic                   stepPending_d;
   logic                   startReq;
   logic                   allDone;
   logic                   logicStart_q;
   logic                   bufSwap_q;
   logic                   busy_q;
   logic [15:0]            genCount_q;

   // Start decision looks only at the registered frame count, so a render pulse
   // arriving in the same cycle only takes effect on the following decision.
   always_comb begin
      divEff = (frame_div_in == '0) ? DIV_WIDTH'(1) : frame_div_in;

      frameCnt_d = frameCnt_q;
      if (state_q == SWAP)
         frameCnt_d = '0;
      else if (render_done_in && (frameCnt_q != '1))
         frameCnt_d = frameCnt_q + 1'b1;

      stepPending_d = (mode_in == 2'b10) && (step_in || (stepPending_q && !logicStart_q));

      startReq = ((mode_in == 2'b01) && (frameCnt_q >= divEff)) ||
                 ((mode_in == 2'b10) && stepPending_q);

      doneMerged = doneMask_q | logic_done_in;
      allDone    = &doneMerged;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= IDLE;
         doneMask_q    <= '0;
         frameCnt_q    <= '0;
         stepPending_q <= 1'b0;
         logicStart_q  <= 1'b0;
         bufSwap_q     <= 1'b0;
         busy_q        <= 1'b0;
         genCount_q    <= 16'd0;
      end else begin
         frameCnt_q    <= frameCnt_d;
         stepPending_q <= stepPending_d;
         logicStart_q  <= 1'b0;
         bufSwap_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (startReq) begin
                  state_q <= WAIT_BUF;
                  busy_q  <= 1'b1;
               end
            end
            WAIT_BUF: begin
               if (buf_ready_in) begin
                  state_q      <= COMPUTE;
                  doneMask_q   <= '0;
                  logicStart_q <= 1'b1;
               end
            end
            COMPUTE: begin
               if (allDone) begin
                  if (render_done_in) begin
                     state_q    <= SWAP;
                     bufSwap_q  <= 1'b1;
                     genCount_q <= genCount_q + 16'd1;
                  end else begin
                     state_q <= WAIT_RENDER;
                  end
               end else begin
                  doneMask_q <= doneMerged;
               end
            end
            WAIT_RENDER: begin
               if (render_done_in) begin
                  state_q    <= SWAP;
                  bufSwap_q  <= 1'b1;
                  genCount_q <= genCount_q + 16'd1;
               end
            end
            SWAP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign logic_start_out = logicStart_q;
   assign buf_swap_out    = bufSwap_q;
   assign busy_out        = busy_q;
   assign gen_count_out   = genCount_q;

endmodule
